// File: rtl/im_loader_ctrl_pkg.sv
// im_ctrl_pkg: shared types and default sizing for the instruction-memory loader
package im_ctrl_pkg;
    localparam int DEF_ADDR_W = 11;
    localparam int DEF_DEPTH  = 2 ** DEF_ADDR_W;
    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;
    typedef logic [1:0] lane_t;
endpackage

// File: rtl/im_loader_ctrl_if.sv
// im_loader_if: host byte link, load control, CPU PC and IM write/address bus
interface im_loader_if import im_ctrl_pkg::*; #(parameter int ADDR_W = DEF_ADDR_W);
    logic              ld_start;
    logic [ADDR_W:0]   ld_len;
    logic              ld_abort;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic [31:0]       pc;
    logic [ADDR_W-1:0] im_addr;
    logic              im_we;
    logic [31:0]       im_wdata;
    logic              cpu_hold;
    logic              ld_busy;
    logic              ld_done;
    logic              ld_err;
    modport master (
        output ld_start, ld_len, ld_abort, byte_valid, byte_data, pc,
        input  byte_ready, im_addr, im_we, im_wdata, cpu_hold, ld_busy, ld_done, ld_err
    );
    modport slave (
        input  ld_start, ld_len, ld_abort, byte_valid, byte_data, pc,
        output byte_ready, im_addr, im_we, im_wdata, cpu_hold, ld_busy, ld_done, ld_err
    );
endinterface

// File: rtl/im_loader_ctrl_packer.sv
// byte_packer: little-endian 4-byte word assembler; lane count wraps after the 4th byte
module byte_packer import im_ctrl_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output lane_t       cnt
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word <= '0;
            cnt  <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            word[8*cnt +: 8] <= din;
            cnt              <= cnt + 2'd1;
        end
    end
endmodule

// File: rtl/im_loader_ctrl.sv
// im_loader_ctrl: loads a byte stream into IM as packed words while holding the CPU
module im_loader_ctrl import im_ctrl_pkg::*; #(parameter int ADDR_W = DEF_ADDR_W) (
    input logic       clk,
    input logic       rst,
    im_loader_if.slave bus
);
    localparam logic [ADDR_W:0] depth = {1'b1, {ADDR_W{1'b0}}};
    state_t          state, state_nx;
    logic [ADDR_W:0] word_idx, len;
    logic [31:0]     pack, wdata_q;
    lane_t           byte_cnt;
    logic            take, start_ok, abort_act, last, hold, err, unused_pc;
    assign take      = bus.byte_valid & bus.byte_ready;
    assign start_ok  = bus.ld_start && bus.ld_len != '0 && bus.ld_len <= depth;
    assign abort_act = bus.ld_abort && (state == COLLECT || state == WRITE);
    assign last      = (word_idx + 1'b1) == len;
    assign unused_pc = ^{bus.pc[31:ADDR_W+2], bus.pc[1:0]};
    byte_packer u_packer (
        .clk  (clk),
        .rst  (rst),
        .clr  ((state == IDLE && start_ok) || abort_act),
        .en   (take),
        .din  (bus.byte_data),
        .word (pack),
        .cnt  (byte_cnt)
    );
    assign bus.byte_ready = state == COLLECT;
    assign bus.ld_busy    = state == COLLECT || state == WRITE;
    assign bus.ld_done    = state == DONE;
    assign bus.im_we      = state == WRITE && !bus.ld_abort;
    assign bus.im_wdata   = bus.im_we ? pack : wdata_q;
    assign bus.im_addr    = bus.ld_busy ? word_idx[ADDR_W-1:0] : bus.pc[ADDR_W+1:2];
    assign bus.cpu_hold   = hold;
    assign bus.ld_err     = err;
    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = start_ok ? COLLECT : IDLE;
            COLLECT: state_nx = abort_act ? IDLE : (take && byte_cnt == 2'd3) ? WRITE : COLLECT;
            WRITE:   state_nx = abort_act ? IDLE : last ? DONE : COLLECT;
            default: state_nx = IDLE;
        endcase
    end
    // hold survives an abort: the CPU must not run a half-loaded program
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            word_idx <= '0;
            len      <= '0;
            wdata_q  <= '0;
            hold     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state <= state_nx;
            err   <= (state == IDLE && bus.ld_start && !start_ok) || abort_act;
            if (state == IDLE && start_ok) begin
                len      <= bus.ld_len;
                word_idx <= '0;
                hold     <= 1'b1;
            end else if (state == DONE) begin
                hold <= 1'b0;
            end
            if (bus.im_we) begin
                wdata_q  <= pack;
                word_idx <= word_idx + 1'b1;
            end
        end
    end
endmodule
